// File: rtl/div_request_sequencer.sv
// div_request_sequencer: operand FIFO, single-issue sequencer and result slot
// in front of the 10-bit by 5-bit restoring divider.
// Optional watchdog: define DIV_TIMEOUT_EN to abort a WAIT that lasts TIMEOUT cycles.
module div_request_sequencer #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [9:0] in_w,
  input  logic [4:0] in_d,
  output logic [9:0] div_w,
  output logic [4:0] div_d,
  output logic       div_start,
  input  logic       div_done,
  input  logic [4:0] div_quo,
  input  logic [5:0] div_rem,
  input  logic       div_ov,
  input  logic       div_dbz,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [4:0] res_quo,
  output logic [5:0] res_rem,
  output logic       res_ov,
  output logic       res_dbz,
  output logic       res_err,
  output logic       busy,
  output logic [7:0] done_cnt
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e state_q, state_d;

  logic [14:0]     mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            in_ready_q;

  logic [9:0] div_w_q;
  logic [4:0] div_d_q;

  logic       res_valid_q;
  logic [4:0] res_quo_q;
  logic [5:0] res_rem_q;
  logic       res_ov_q, res_dbz_q;
  logic [7:0] done_cnt_q;

  logic push, pop, accept, capture, abort;

  assign push    = in_valid && in_ready_q;
  assign accept  = res_valid_q && res_ready;
  assign capture = (state_q == StWait) && div_done;

`ifdef DIV_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);

  logic [TmoW-1:0] tmo_q;
  logic            res_err_q;

  // WAIT-cycle counter; cleared while issuing so every WAIT starts from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_q <= '0;
    end else if (state_q == StIssue) begin
      tmo_q <= '0;
    end else if (state_q == StWait) begin
      tmo_q <= tmo_q + TmoW'(1);
    end
  end

  // A done on the final WAIT cycle wins over the watchdog.
  assign abort = (state_q == StWait) && !div_done && (tmo_q == TmoW'(TIMEOUT - 1));

  // Error flag travels with the slot contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_err_q <= 1'b0;
    end else if (capture) begin
      res_err_q <= 1'b0;
    end else if (abort) begin
      res_err_q <= 1'b1;
    end
  end

  assign res_err = res_err_q;
`else
  assign abort   = 1'b0;
  assign res_err = 1'b0;
`endif

  // FIFO occupancy next-state.
  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // FIFO pointers, count and registered ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      in_ready_q <= 1'b1;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      cnt_q      <= cnt_d;
      in_ready_q <= (cnt_d != FullCnt);
    end
  end

  // FIFO storage; contents are don't-care once the pointers reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_w, in_d};
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // FSM next-state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (pop) state_d = StIssue;
      StIssue: state_d = StWait;
      StWait:  if (capture || abort) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs: pop only when the slot is free or draining this cycle.
  always_comb begin
    pop       = (state_q == StIdle) && (cnt_q != '0) && (!res_valid_q || res_ready);
    div_start = (state_q == StIssue);
    busy      = (state_q != StIdle) || (cnt_q != '0);
  end

  // Operand hold register, stable from ISSUE through WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_w_q <= '0;
      div_d_q <= '0;
    end else if (pop) begin
      {div_w_q, div_d_q} <= mem_q[rd_ptr_q];
    end
  end

  // Result slot and accepted-result counter; a capture overrides a same-cycle accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid_q <= 1'b0;
      res_quo_q   <= '0;
      res_rem_q   <= '0;
      res_ov_q    <= 1'b0;
      res_dbz_q   <= 1'b0;
      done_cnt_q  <= '0;
    end else begin
      if (capture) begin
        res_valid_q <= 1'b1;
        res_quo_q   <= div_quo;
        res_rem_q   <= div_rem;
        res_ov_q    <= div_ov;
        res_dbz_q   <= div_dbz;
      end else if (abort) begin
        res_valid_q <= 1'b1;
        res_quo_q   <= '0;
        res_rem_q   <= '0;
        res_ov_q    <= 1'b0;
        res_dbz_q   <= 1'b0;
      end else if (accept) begin
        res_valid_q <= 1'b0;
      end
      if (accept) done_cnt_q <= done_cnt_q + 8'd1;
    end
  end

  assign in_ready  = in_ready_q;
  assign div_w     = div_w_q;
  assign div_d     = div_d_q;
  assign res_valid = res_valid_q;
  assign res_quo   = res_quo_q;
  assign res_rem   = res_rem_q;
  assign res_ov    = res_ov_q;
  assign res_dbz   = res_dbz_q;
  assign done_cnt  = done_cnt_q;

endmodule

// File: tb/tb_div_request_sequencer.sv
// Bench for div_request_sequencer: directed steps plus a randomized stream,
// with a behavioural divider stub and an in-order result scoreboard.
module tb_div_request_sequencer;

  localparam int unsigned Depth = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [9:0] in_w = '0;
  logic [4:0] in_d = '0;
  logic [9:0] div_w;
  logic [4:0] div_d;
  logic       div_start;
  logic       div_done = 1'b0;
  logic [4:0] div_quo = '0;
  logic [5:0] div_rem = '0;
  logic       div_ov = 1'b0;
  logic       div_dbz = 1'b0;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [4:0] res_quo;
  logic [5:0] res_rem;
  logic       res_ov;
  logic       res_dbz;
  logic       res_err;
  logic       busy;
  logic [7:0] done_cnt;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;
  int n_acc = 0;
  int lat_min = 1;
  int lat_max = 4;
  bit spurious_en = 1'b0;

  div_request_sequencer #(
    .FIFO_DEPTH (Depth),
    .TIMEOUT    (64)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_w      (in_w),
    .in_d      (in_d),
    .div_w     (div_w),
    .div_d     (div_d),
    .div_start (div_start),
    .div_done  (div_done),
    .div_quo   (div_quo),
    .div_rem   (div_rem),
    .div_ov    (div_ov),
    .div_dbz   (div_dbz),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_quo   (res_quo),
    .res_rem   (res_rem),
    .res_ov    (res_ov),
    .res_dbz   (res_dbz),
    .res_err   (res_err),
    .busy      (busy),
    .done_cnt  (done_cnt)
  );

  always #5 clk = ~clk;

  // Divider behaviour as seen by this block: {quo, rem, ov, dbz}.
  // Saturated quotient on overflow / divide-by-zero is this stub's own choice.
  function automatic logic [12:0] ref_div(input logic [9:0] w, input logic [4:0] d);
    int unsigned q;
    if (d == 5'd0) return {5'h1f, 6'h00, 1'b0, 1'b1};
    q = int'(w) / int'(d);
    if (q > 31) return {5'h1f, 6'h00, 1'b1, 1'b0};
    return {5'(q), 6'(int'(w) % int'(d)), 2'b00};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int max_cycles);
    int n;
    n = 0;
    @(negedge clk);
    while ((busy !== 1'b0 || res_valid !== 1'b0) && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    chk("drain_bound", 32'(n >= max_cycles), 32'(0));
  endtask

  // Divider stub: answers each start after lat_min..lat_max WAIT cycles,
  // reading operands at done time; garbage on result lines otherwise.
  initial begin
    bit          rst_seen;
    bit          pending;
    int          lat;
    logic [12:0] r;
    pending = 1'b0;
    lat = 0;
    forever begin
      @(posedge clk);
      rst_seen = rst;
      #2;
      div_done = 1'b0;
      div_quo  = 5'($urandom);
      div_rem  = 6'($urandom);
      div_ov   = 1'($urandom);
      div_dbz  = 1'($urandom);
      if (rst_seen) begin
        pending = 1'b0;
      end else if (pending) begin
        lat--;
        if (lat <= 0) begin
          r = ref_div(div_w, div_d);
          {div_quo, div_rem, div_ov, div_dbz} = r;
          div_done = 1'b1;
          pending  = 1'b0;
        end
      end else if (div_start) begin
        pending = 1'b1;
        lat = int'($urandom_range(32'(lat_max), 32'(lat_min)));
      end else if (spurious_en && $urandom_range(7, 0) == 0) begin
        div_done = 1'b1;
      end
    end
  end

  // Scoreboard: operands in push order, checked against each accepted result.
  logic [14:0] exp_q[$];
  logic [14:0] op;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (res_valid && res_ready) begin
        chk("result_expected", 32'(exp_q.size() != 0), 32'(1));
        if (exp_q.size() != 0) begin
          op = exp_q.pop_front();
          chk("result", 32'({res_quo, res_rem, res_ov, res_dbz, res_err}),
              32'({ref_div(op[14:5], op[4:0]), 1'b0}));
          n_acc++;
        end
      end
      if (in_valid && in_ready) exp_q.push_back({in_w, in_d});
    end
  end

  initial begin
    int acc;
    int pushes;
    int cyc;
    int seen;
    int acc_base;

    // Reset state.
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    chk("rst_div_start", 32'(div_start), 32'(0));
    chk("rst_div_w", 32'(div_w), 32'(0));
    chk("rst_div_d", 32'(div_d), 32'(0));
    chk("rst_res_valid", 32'(res_valid), 32'(0));
    chk("rst_res_fields", 32'({res_quo, res_rem, res_ov, res_dbz, res_err}), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done_cnt", 32'(done_cnt), 32'(0));
    tick();
    rst = 1'b0;

    // Single division 100/7 and its issue latency.
    tick();
    res_ready = 1'b1;
    in_valid = 1'b1;
    in_w = 10'd100;
    in_d = 5'd7;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_c1_start", 32'(div_start), 32'(0));
    chk("lat_c1_busy", 32'(busy), 32'(1));
    @(negedge clk);
    chk("lat_c2_start", 32'(div_start), 32'(1));
    chk("lat_c2_div_w", 32'(div_w), 32'(100));
    chk("lat_c2_div_d", 32'(div_d), 32'(7));
    @(negedge clk);
    chk("start_one_cycle", 32'(div_start), 32'(0));
    wait_idle(50);
    chk("done_cnt_1", 32'(done_cnt), 32'(1));

    // Overflow then divide-by-zero, back to back.
    tick();
    in_valid = 1'b1;
    in_w = 10'd1000;
    in_d = 5'd3;
    tick();
    in_w = 10'd50;
    in_d = 5'd0;
    tick();
    in_valid = 1'b0;
    wait_idle(50);
    chk("done_cnt_3", 32'(done_cnt), 32'(3));

    // Capacity with the result slot blocked.
    acc = 0;
    tick();
    res_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_w = 10'($urandom);
      in_d = 5'($urandom_range(31, 1));
      @(negedge clk);
      if (in_valid && in_ready) acc++;
      if (i != 19) tick();
    end
    chk("capacity_accepted", 32'(acc), 32'(Depth + 1));
    chk("capacity_in_ready", 32'(in_ready), 32'(0));
    chk("capacity_res_valid", 32'(res_valid), 32'(1));
    tick();
    in_valid = 1'b0;
    res_ready = 1'b1;
    wait_idle(100);
    chk("done_cnt_8", 32'(done_cnt), 32'(8));

    // Reset while waiting on the divider with entries queued.
    lat_min = 30;
    lat_max = 30;
    for (int i = 0; i < 4; i++) begin
      tick();
      in_valid = 1'b1;
      in_w = 10'(200 + i);
      in_d = 5'(i + 3);
    end
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'(1));
    chk("pre_rst_in_ready", 32'(in_ready), 32'(1));
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_res_valid", 32'(res_valid), 32'(0));
    chk("mid_rst_in_ready", 32'(in_ready), 32'(1));
    chk("mid_rst_busy", 32'(busy), 32'(0));
    chk("mid_rst_done_cnt", 32'(done_cnt), 32'(0));
    lat_min = 1;
    lat_max = 4;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (res_valid || busy) seen++;
    end
    chk("no_stale_after_rst", 32'(seen), 32'(0));

    // Randomized stream with spurious done pulses and random backpressure.
    spurious_en = 1'b1;
    acc_base = n_acc;
    pushes = 0;
    cyc = 0;
    while (pushes < 300 && cyc < 20000) begin
      tick();
      in_valid = ($urandom_range(3, 0) != 0);
      in_w = 10'($urandom);
      in_d = 5'($urandom);
      res_ready = 1'($urandom);
      @(negedge clk);
      if (in_valid && in_ready) pushes++;
      cyc++;
    end
    tick();
    in_valid = 1'b0;
    res_ready = 1'b1;
    wait_idle(400);
    spurious_en = 1'b0;
    chk("random_pushes", 32'(pushes), 32'(300));
    chk("random_results", 32'(n_acc - acc_base), 32'(300));
    chk("random_done_cnt", 32'(done_cnt), 32'(300 % 256));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/div_request_sequencer.md
Name: div_request_sequencer

Overview:
- Upstream feeder and result collector for the 10-bit by 5-bit restoring divider.
- Buffers operand pairs in a small FIFO using a valid/ready handshake.
- Issues one division at a time to the divider. Captures quotient, remainder and status flags on done, then presents them downstream through a valid/ready output slot.
- Lets the surrounding system stream divisions without tracking the divider's multi-cycle timing.

Parameters:
- FIFO_DEPTH, 4, operand FIFO entries; power of two, 2..16.
- TIMEOUT, 64, cycles allowed in WAIT before watchdog abort; used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  FIFO can accept; equals !full, registered.
- in_w  in  10  dividend.
- in_d  in  5  divisor.
- div_w  out  10  dividend to divider.
- div_d  out  5  divisor to divider.
- div_start  out  1  one-cycle start pulse.
- div_done  in  1  divider result valid.
- div_quo  in  5  divider quotient.
- div_rem  in  6  divider remainder.
- div_ov  in  1  divider overflow flag.
- div_dbz  in  1  divider divide-by-zero flag.
- res_valid  out  1  result slot full.
- res_ready  in  1  downstream accepts.
- res_quo  out  5  captured quotient.
- res_rem  out  6  captured remainder.
- res_ov  out  1  captured overflow flag.
- res_dbz  out  1  captured divide-by-zero flag.
- res_err  out  1  watchdog abort flag; tied 0 without the feature.
- busy  out  1  FSM not in IDLE, or FIFO non-empty.
- done_cnt  out  8  results accepted downstream; wraps 255->0.

Behaviour:
- Reset (rst=1 at posedge) applies regardless of state, including mid-division:
  - FIFO emptied and FSM to IDLE.
  - in_ready=1 and div_start=0.
  - div_w=0, div_d=0.
  - res_valid=0, and all res_* fields = 0.
  - busy=0, done_cnt=0.
  - Divider shares rst, so both restart together.
- FIFO:
  - Push on in_valid && in_ready.
  - in_ready is registered from full: when full, a same-cycle pop does not admit a push.
  - Pop only by the FSM in IDLE. Push and pop in the same cycle leave the count unchanged.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE: if FIFO non-empty and (!res_valid || res_ready), pop the head into div_w/div_d and go to ISSUE.
  - ISSUE: div_start=1 for exactly this cycle; go to WAIT.
  - WAIT: on div_done=1, register div_quo/div_rem/div_ov/div_dbz into the res_* fields, set res_valid=1 on the next edge, and go to IDLE.
- Operand and pulse timing:
  - div_w/div_d stay stable from ISSUE until div_done is sampled.
  - div_done in IDLE or ISSUE is ignored.
- Latency: a push in cycle 0 into an empty, idle block gives pop in cycle 1 and div_start in cycle 2. res_valid rises the cycle after div_done.
- Result slot:
  - res_* hold until res_valid && res_ready, after which res_valid=0 and done_cnt increments by 1.
  - A new capture in the same cycle as an accept overwrites the slot; res_valid stays 1 and done_cnt still increments.
- Capacity: at most one division in flight. With res_ready=0, total accepted = 1 in flight + FIFO_DEPTH buffered.
- Flags pass through unchanged; this block does no arithmetic on them.

Optional Feature:
- Macro: DIV_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT with no div_done, capture res_quo=0, res_rem=0, res_ov=0, res_dbz=0, res_err=1, and go to IDLE.
  - A div_done on that same cycle takes priority, giving a normal capture with res_err=0.
- Undefined: no counter; WAIT waits indefinitely; res_err is constant 0.

Test Plan:
- Push in_w=100, in_d=7 with res_ready=1 -> div_start in cycle 2; res_quo=14, res_rem=2, res_ov=0, res_dbz=0; done_cnt=1.
- Push 1000/3 -> res_ov=1. Then push 50/0 -> res_dbz=1. Results arrive in push order.
- res_ready=0 and in_valid held high -> exactly 5 pairs accepted, then in_ready=0. Release res_ready -> 5 results in push order; done_cnt=5.
- Assert rst during WAIT with 3 entries queued -> next cycle FIFO empty, res_valid=0, in_ready=1, busy=0. No stale result appears afterward.
- Toggle res_ready randomly over 300 pushes of random w/d -> every result matches w/d, or flags set when the quotient exceeds 31 or d=0. done_cnt=300 mod 256=44.
- With DIV_TIMEOUT_EN and a stub holding div_done=0 -> res_valid rises TIMEOUT cycles after WAIT entry with res_err=1; the next queued op issues normally.
